// File: rtl/renorm_byte_pipe.sv
// renorm_byte_pipe: range-coder renormalisation stage emitting pre-carry bytes with flush support
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   in_valid/in_ready     symbol handshake; in_ready is high only in IDLE
//   in_low_inc, in_range  addend to low and unnormalised (nonzero) range of the symbol
//   flush_req/done        level flush request; done pulses for one cycle when the flush completes
//   out_valid/out_ready   byte handshake; out_data is {carry, byte[7:0]}
//   out_range, out_cnt    normalised range register and signed count register
module renorm_byte_pipe #(
    parameter int RANGE_WIDTH = 16,
    parameter int LOW_WIDTH   = 32,
    parameter int CNT_WIDTH   = 6
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LOW_WIDTH-1:0]        in_low_inc,
    input  logic [RANGE_WIDTH-1:0]      in_range,
    input  logic                        flush_req,
    output logic                        done,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [8:0]                  out_data,
    output logic [RANGE_WIDTH-1:0]      out_range,
    output logic signed [CNT_WIDTH-1:0] out_cnt
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] EMIT  = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam logic [RANGE_WIDTH-1:0]      RANGE_INIT = {1'b1, {(RANGE_WIDTH-1){1'b0}}};
    localparam logic signed [CNT_WIDTH-1:0] CNT_INIT   = CNT_WIDTH'(-9);
    localparam logic [LOW_WIDTH-1:0]        HALF       = LOW_WIDTH'(1) << (RANGE_WIDTH-2);
    localparam logic [LOW_WIDTH-1:0]        FMASK      = HALF - LOW_WIDTH'(1);

    logic [1:0]                   state_q, state_d;
    logic [LOW_WIDTH-1:0]         low_q, low_d;
    logic [RANGE_WIDTH-1:0]       range_q, range_d;
    logic signed [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [8:0]                   buf0_q, buf0_d, buf1_q, buf1_d;
    logic [1:0]                   npend_q, npend_d;

    int                           d, c, s, sf;
    logic [LOW_WIDTH-1:0]         sum, m, l1, acc_low, e;
    logic [8:0]                   b0, b1;
    logic [1:0]                   acc_n;
    logic signed [CNT_WIDTH-1:0]  acc_cnt;

    // d ends up as the leading-zero count: the highest set bit is visited last
    always_comb begin
        d = RANGE_WIDTH;
        for (int i = 0; i < RANGE_WIDTH; i++)
            if (in_range[i]) d = RANGE_WIDTH - 1 - i;
    end

    // c doubles as the flush shift: the flush byte is low >> (cnt+RANGE_WIDTH) and m its mask
    always_comb begin
        c       = int'(cnt_q) + RANGE_WIDTH;
        s       = int'(cnt_q) + d;
        sf      = int'(cnt_q) + RANGE_WIDTH - 6;
        sum     = low_q + in_low_inc;
        m       = ~({LOW_WIDTH{1'b1}} << c);
        l1      = sum & m;
        b0      = 9'(sum >> c);
        b1      = 9'(l1 >> (c - 8));
        acc_low = (s < 0) ? sum << d : (s < 8) ? l1 << d : (l1 & (m >> 8)) << d;
        acc_cnt = CNT_WIDTH'((s < 0) ? s : (s < 8) ? s - 8 : s - 16);
        acc_n   = (s < 0) ? 2'd0 : (s < 8) ? 2'd1 : 2'd2;
        e       = ((low_q + FMASK) & ~FMASK) | HALF;
    end

    always_comb begin
        state_d = state_q;
        low_d   = low_q;
        range_d = range_q;
        cnt_d   = cnt_q;
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        npend_d = npend_q;
        if (state_q == IDLE && in_valid) begin
            low_d   = acc_low;
            range_d = in_range << d;
            cnt_d   = acc_cnt;
            buf0_d  = b0;
            buf1_d  = b1;
            npend_d = acc_n;
            state_d = (acc_n != 2'd0) ? EMIT : IDLE;
        end else if (state_q == IDLE && flush_req) begin
            // the rounded end value e lives in low for the rest of the flush
            low_d   = e;
            state_d = (sf > 0) ? FLUSH : DONE;
        end else if (state_q == EMIT && out_ready) begin
            buf0_d  = buf1_q;
            npend_d = npend_q - 2'd1;
            state_d = (npend_q == 2'd1) ? IDLE : EMIT;
        end else if (state_q == FLUSH && out_ready) begin
            // cnt walks down by 8 per byte, so the remaining-bits count stays cnt+RANGE_WIDTH-6
            low_d   = low_q & m;
            cnt_d   = cnt_q - CNT_WIDTH'(8);
            state_d = (sf - 8 > 0) ? FLUSH : DONE;
        end else if (state_q == DONE) begin
            low_d   = '0;
            range_d = RANGE_INIT;
            cnt_d   = CNT_INIT;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            low_q   <= '0;
            range_q <= RANGE_INIT;
            cnt_q   <= CNT_INIT;
            buf0_q  <= '0;
            buf1_q  <= '0;
            npend_q <= '0;
        end else begin
            state_q <= state_d;
            low_q   <= low_d;
            range_q <= range_d;
            cnt_q   <= cnt_d;
            buf0_q  <= buf0_d;
            buf1_q  <= buf1_d;
            npend_q <= npend_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == EMIT || state_q == FLUSH;
    assign done      = state_q == DONE;
    assign out_data  = (state_q == FLUSH) ? 9'(low_q >> c) : buf0_q;
    assign out_range = range_q;
    assign out_cnt   = cnt_q;
endmodule

// File: tb/tb_renorm_byte_pipe.sv
// tb_renorm_byte_pipe: directed and random checks of renorm_byte_pipe against a queue-based byte model
module tb_renorm_byte_pipe;
    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_low_inc = '0;
    logic [15:0]       in_range = 16'h8000;
    logic              flush_req = 1'b0;
    logic              done;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [8:0]        out_data;
    logic [15:0]       out_range;
    logic signed [5:0] out_cnt;

    int          errors = 0;
    int          checks = 0;
    longint      m_low = 0;
    int          m_cnt = -9;
    int          m_range = 'h8000;
    logic [8:0]  exp_q[$];

    renorm_byte_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_low_inc(in_low_inc), .in_range(in_range), .flush_req(flush_req), .done(done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_range(out_range), .out_cnt(out_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_range"}, {16'd0, out_range}, 32'(m_range));
        chk({tag, "_cnt"}, {26'd0, out_cnt}, {26'd0, 6'(m_cnt)});
    endtask

    task automatic model_reset();
        m_low = 0;
        m_cnt = -9;
        m_range = 'h8000;
    endtask

    task automatic model_accept(input longint inc, input int rng);
        longint lw, mm;
        int d, c, s;
        lw = (m_low + inc) & 64'hFFFF_FFFF;
        d = 0;
        while (((rng << d) & 'h8000) == 0) d++;
        c = m_cnt;
        s = c + d;
        if (s >= 0) begin
            c += 16;
            mm = (longint'(1) << c) - 1;
            if (s >= 8) begin
                exp_q.push_back(9'(lw >> c));
                lw &= mm;
                c -= 8;
                mm >>= 8;
            end
            exp_q.push_back(9'(lw >> c));
            s = c + d - 24;
            lw &= mm;
        end
        m_low = (lw << d) & 64'hFFFF_FFFF;
        m_cnt = s;
        m_range = (rng << d) & 'hFFFF;
    endtask

    task automatic model_flush();
        longint e, n;
        int c, s;
        c = m_cnt;
        s = c + 10;
        e = ((m_low + 'h3FFF) & ~longint'('h3FFF)) | 'h4000;
        if (s > 0) begin
            n = (longint'(1) << (c + 16)) - 1;
            do begin
                exp_q.push_back(9'(e >> (c + 16)));
                e &= n;
                s -= 8;
                c -= 8;
                n >>= 8;
            end while (s > 0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        exp_q.delete();
    endtask

    task automatic drain(input int stall);
        int cyc;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            out_ready = (cyc < stall) ? 1'b0 : (cyc > 20) ? 1'b1 : 1'($urandom_range(0, 1));
            chk("out_valid", {31'd0, out_valid}, 32'd1);
            chk("out_data", {23'd0, out_data}, {23'd0, exp_q[0]});
            chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
            if (out_ready) void'(exp_q.pop_front());
            cyc++;
        end
        out_ready = 1'b0;
        chk("drain_bound", {31'd0, cyc < 200}, 32'd1);
    endtask

    task automatic send(input logic [31:0] inc, input logic [15:0] rng, input int stall);
        in_valid = 1'b1;
        in_low_inc = inc;
        in_range = rng;
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_accept(64'(inc), int'(rng));
        drain(stall);
        chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
        chk_regs("sym");
    endtask

    task automatic do_flush(input bit hold);
        model_flush();
        flush_req = 1'b1;
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        drain(0);
        chk("done_high", {31'd0, done}, 32'd1);
        chk("done_out_valid", {31'd0, out_valid}, 32'd0);
        chk("done_in_ready", {31'd0, in_ready}, 32'd0);
        if (!hold) flush_req = 1'b0;
        @(posedge clk); #1;
        model_reset();
        chk("done_low", {31'd0, done}, 32'd0);
        chk("reinit_in_ready", {31'd0, in_ready}, 32'd1);
        chk_regs("reinit");
    endtask

    initial begin
        do_reset();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_range", {16'd0, out_range}, 32'h8000);
        chk("rst_cnt", {26'd0, out_cnt}, {26'd0, 6'h37});
        send(32'h0, 16'h8000, 0);
        chk("r030_range", {16'd0, out_range}, 32'h8000);
        do_reset();
        send(32'h1234, 16'h0040, 0);
        chk("r031_cnt", {26'd0, out_cnt}, {26'd0, 6'h38});
        do_flush(1'b0);
        do_reset();
        send(32'h00FF, 16'h0100, 0);
        chk("r032_cnt_a", {26'd0, out_cnt}, {26'd0, 6'h3E});
        send(32'h0, 16'h0001, 5);
        chk("r032_cnt_b", {26'd0, out_cnt}, {26'd0, 6'h3D});
        do_reset();
        do_flush(1'b1);
        do_flush(1'b0);
        do_reset();
        in_valid = 1'b1;
        in_low_inc = 32'h1234;
        in_range = 16'h0040;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("emit_valid", {31'd0, out_valid}, 32'd1);
        chk("emit_data", {23'd0, out_data}, 32'h024);
        out_ready = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b0;
        model_reset();
        exp_q.delete();
        chk("r035_out_valid", {31'd0, out_valid}, 32'd0);
        chk("r035_in_ready", {31'd0, in_ready}, 32'd1);
        chk_regs("r035");
        @(posedge clk); #1;
        chk("r035_no_byte", {31'd0, out_valid}, 32'd0);
        do_flush(1'b0);
        for (int i = 0; i < 80; i++) begin
            if (i % 12 == 11) do_flush(1'b0);
            else begin
                logic [15:0] r;
                r = 16'($urandom_range(1, 16'hFFFF) >> $urandom_range(0, 15));
                if (r == 16'd0) r = 16'd1;
                send(32'($urandom_range(0, 16'hFFFF)), r, int'($urandom_range(0, 2)));
            end
        end
        do_flush(1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/renorm_byte_pipe.md
RENORM_BYTE_PIPE -- requirements
Module: renorm_byte_pipe

Interface
REQ-001 SHALL have parameter RANGE_WIDTH, default 16, meaning the range register width; the low-window constant is RANGE_WIDTH+8.
REQ-002 SHALL have parameter LOW_WIDTH, default 32, meaning the low register width; LOW_WIDTH >= RANGE_WIDTH+16.
REQ-003 SHALL have parameter CNT_WIDTH, default 6, meaning the signed count register width.
REQ-004 SHALL have ports: clk in 1, the single clock; reset in 1, synchronous active-high reset.
REQ-005 SHALL have ports: in_valid in 1, symbol request; in_ready out 1, symbol accept; in_low_inc in LOW_WIDTH, addend to low; in_range in RANGE_WIDTH, unnormalised range (nonzero).
REQ-006 SHALL have ports: flush_req in 1, level flush request; done out 1, one-cycle flush-complete pulse.
REQ-007 SHALL have ports: out_valid out 1, byte available; out_ready in 1, byte consumed; out_data out 9, pre-carry byte {carry, byte[7:0]}.
REQ-008 SHALL have ports: out_range out RANGE_WIDTH, normalised range register; out_cnt out CNT_WIDTH, signed count register.

Function
REQ-009 SHALL hold state registers low (LOW_WIDTH), range (RANGE_WIDTH), cnt (signed CNT_WIDTH), and a 2-entry pending byte buffer.
REQ-010 SHALL implement FSM states IDLE, EMIT, FLUSH, DONE; in_ready = (state == IDLE) and is combinational.
REQ-011 SHALL accept a symbol on a clk edge with in_valid && in_ready; in IDLE a symbol takes priority over flush_req.
REQ-012 On accept: L = low + in_low_inc (mod 2^LOW_WIDTH); d = leading-zero count of in_range; c = cnt + RANGE_WIDTH; s = cnt + d; m = 2^c - 1.
REQ-013 If s < 0: no bytes; low <= L << d; cnt <= s.
REQ-014 If 0 <= s < 8: emit byte L >> c; low <= (L & m) << d; cnt <= c + d - (RANGE_WIDTH+8).
REQ-015 If s >= 8: emit L >> c; L1 = L & m; emit L1 >> (c-8); low <= (L1 & (m >> 8)) << d; cnt <= c - 8 + d - (RANGE_WIDTH+8).
REQ-016 On accept, range SHALL be set to in_range << d; all register updates SHALL be visible in the cycle after accept.
REQ-017 Emitted bytes SHALL be truncated to 9 bits and loaded into the pending buffer in order; next state is EMIT if any byte is pending, else IDLE, so the zero-byte throughput is one symbol per cycle.
REQ-018 In EMIT, out_valid SHALL be 1 and out_data the head byte, held stable while out_ready = 0.
REQ-019 In EMIT, each out_valid && out_ready edge SHALL pop one byte; the pop of the last byte SHALL return the FSM to IDLE on that edge.
REQ-020 In IDLE with flush_req = 1 and in_valid = 0, the FSM SHALL enter FLUSH with M = 2^(RANGE_WIDTH-2) - 1, e = ((low + M) & ~M) | (M+1), s = cnt + RANGE_WIDTH - 6, n = 2^(cnt+RANGE_WIDTH) - 1.
REQ-021 On FLUSH entry, if s <= 0 the FSM SHALL go directly to DONE.
REQ-022 FLUSH SHALL present e >> (cnt+RANGE_WIDTH-8*k) for k = 0, 1, ... as out_data, one byte per handshake, masking e with n and then n >>= 8 after each byte, s -= 8 per byte, stopping when s <= 0.
REQ-023 After the last flush byte handshake, the FSM SHALL enter DONE.
REQ-024 DONE SHALL last exactly one cycle with done = 1; it SHALL reload low = 0, range = 2^(RANGE_WIDTH-1), cnt = -9; next state IDLE.
REQ-025 The requester drops flush_req on done; flush_req still high in IDLE after DONE SHALL start a new flush.
REQ-026 out_valid SHALL never be 1 in IDLE or DONE; in_ready SHALL never be 1 outside IDLE.

Reset
REQ-027 reset SHALL force state IDLE, low = 0, range = 2^(RANGE_WIDTH-1), cnt = -9, clear the pending buffer, out_valid = 0, done = 0.
REQ-028 reset asserted in EMIT or FLUSH SHALL discard pending or flush bytes; no byte SHALL be presented after reset.
REQ-029 reset SHALL take priority over any simultaneous handshake.

Verification
REQ-030 Reset, then in_range = 0x8000 and in_low_inc = 0 -> no byte; out_range = 0x8000; out_cnt = -9; in_ready high the next cycle.
REQ-031 From reset, in_range = 0x0040 and in_low_inc = 0x1234 -> one byte 0x024; low = 0x6800; out_cnt = -8; out_range = 0x8000.
REQ-032 From reset, send {0x00FF, 0x0100} then {0, 0x0001} -> first symbol gives no byte and cnt = -2; second gives bytes 0x001 then 0x0FE; low = 0; cnt = -3.
REQ-033 Hold out_ready = 0 for 5 cycles during REQ-032 bytes -> out_data stable; in_ready = 0; no byte lost or duplicated.
REQ-034 Flush from reset -> one byte 0x080, then done for one cycle, then state reinitialised.
REQ-035 Assert reset during EMIT with one byte pending -> out_valid = 0 the next cycle; registers at reset values.
